ofs_fim_csr_regbank: RTL and testbench

Register bank that consumes the flat CSR write/read strobes produced by the AXI-4 CSR slave and returns read data. Implements a DFH, four scratchpads, sticky RW1C status, a saturating event counter and a control register. Writes are committed through a one-stage pipeline with `csr_slv_wready` back-pressure. Reads return data with fixed 2-cycle latency.

---
 rtl/ofs_fim_csr_regbank.sv | 176 +++++++++++++++++
 tb/tb_ofs_fim_csr_regbank.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_fim_csr_regbank.sv
// CSR register bank: DFH, four scratchpads, RW1C status, saturating event counter, control.
// Writes commit one cycle after acceptance; reads return with a fixed two-cycle latency.
`timescale 1ns/1ps

package ofs_fim_cfg_pkg;
    parameter int MMIO_ADDR_WIDTH = 16;
endpackage

package ofs_csr_pkg;
    typedef enum logic [1:0] {
        LOWER32 = 2'd0,
        UPPER32 = 2'd1,
        FULL64  = 2'd2
    } csr_access_type_t;
endpackage

module ofs_fim_csr_regbank #(
    parameter int          ADDR_WIDTH  = ofs_fim_cfg_pkg::MMIO_ADDR_WIDTH,
    parameter int          DATA_WIDTH  = 64,
    parameter int          WSTRB_WIDTH = DATA_WIDTH/8,
    parameter logic [63:0] DFH_VALUE   = 64'h3000_0000_0000_1000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           csr_write,
    input  logic [ADDR_WIDTH-1:0]          csr_waddr,
    input  ofs_csr_pkg::csr_access_type_t  csr_write_type,
    input  logic [DATA_WIDTH-1:0]          csr_wdata,
    input  logic [WSTRB_WIDTH-1:0]         csr_wstrb,
    output logic                           csr_slv_wready,
    input  logic                           csr_read,
    input  logic [ADDR_WIDTH-1:0]          csr_raddr,
    input  logic                           csr_read_32b,
    output logic [DATA_WIDTH-1:0]          csr_readdata,
    output logic                           csr_readdata_valid,
    input  logic [15:0]                    evt_in,
    output logic [7:0]                     ctrl_out
);

    logic                   wready_q, pend_q;
    logic [ADDR_WIDTH-1:3]  waddr_q;
    logic [DATA_WIDTH-1:0]  wdata_q, wmask;
    logic [WSTRB_WIDTH-1:0] wbe_q, type_mask;
    logic                   accept, commit;
    logic [2:0]             widx;

    logic [DATA_WIDTH-1:0]  scratch_q [4];
    logic [DATA_WIDTH-1:0]  scratch_d [4];
    logic [15:0]            status_q, status_d, status_clr;
    logic [31:0]            evt_cnt_q, evt_cnt_d;
    logic [7:0]             ctrl_q, ctrl_d;

    logic [DATA_WIDTH-1:0]  rd_mux, rd_sel, rd1_q, rdata_q;
    logic                   rd1_v_q, rvalid_q;

    logic                   unused_ok;
    assign unused_ok = ^{csr_raddr[1:0], csr_waddr[2:0]};

    always_comb begin
        case (csr_write_type)
            ofs_csr_pkg::LOWER32: type_mask = WSTRB_WIDTH'(8'h0F);
            ofs_csr_pkg::UPPER32: type_mask = WSTRB_WIDTH'(8'hF0);
            ofs_csr_pkg::FULL64:  type_mask = WSTRB_WIDTH'(8'hFF);
            default:              type_mask = '0;
        endcase
    end

    assign accept = csr_write && wready_q;
    assign widx   = waddr_q[5:3];
    // A commit with no effective bytes must not touch any register, including the clear-on-write ones.
    assign commit = pend_q && (waddr_q[ADDR_WIDTH-1:6] == '0) && (|wbe_q);

    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < WSTRB_WIDTH; i++) begin
            wmask[i*8 +: 8] = {8{wbe_q[i]}};
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            scratch_d[i] = scratch_q[i];
            if (commit && widx == 3'(i + 1)) begin
                scratch_d[i] = (scratch_q[i] & ~wmask) | (wdata_q & wmask);
            end
        end

        status_clr = '0;
        if (commit && widx == 3'd5) begin
            status_clr = wdata_q[15:0] & wmask[15:0];
        end
        status_d = (status_q & ~status_clr) | evt_in;

        if (commit && widx == 3'd6) begin
            evt_cnt_d = {31'b0, evt_in[0]};
        end else if (evt_in[0] && evt_cnt_q != '1) begin
            evt_cnt_d = evt_cnt_q + 32'd1;
        end else begin
            evt_cnt_d = evt_cnt_q;
        end

        ctrl_d = ctrl_q;
        if (commit && widx == 3'd7) begin
            ctrl_d = (ctrl_q & ~wmask[7:0]) | (wdata_q[7:0] & wmask[7:0]);
        end
    end

    always_comb begin
        rd_mux = '0;
        if (csr_raddr[ADDR_WIDTH-1:6] == '0) begin
            case (csr_raddr[5:3])
                3'd0:    rd_mux = DFH_VALUE;
                3'd1:    rd_mux = scratch_q[0];
                3'd2:    rd_mux = scratch_q[1];
                3'd3:    rd_mux = scratch_q[2];
                3'd4:    rd_mux = scratch_q[3];
                3'd5:    rd_mux = DATA_WIDTH'(status_q);
                3'd6:    rd_mux = DATA_WIDTH'(evt_cnt_q);
                default: rd_mux = DATA_WIDTH'(ctrl_q);
            endcase
        end
        rd_sel = rd_mux;
        if (csr_read_32b && csr_raddr[2]) begin
            rd_sel = {rd_mux[DATA_WIDTH-1:DATA_WIDTH/2], rd_mux[DATA_WIDTH-1:DATA_WIDTH/2]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wready_q  <= 1'b0;
            pend_q    <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wbe_q     <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                scratch_q[i] <= '0;
            end
            status_q  <= '0;
            evt_cnt_q <= '0;
            ctrl_q    <= '0;
            rd1_v_q   <= 1'b0;
            rd1_q     <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            wready_q <= !accept;
            pend_q   <= accept;
            if (accept) begin
                waddr_q <= csr_waddr[ADDR_WIDTH-1:3];
                wdata_q <= csr_wdata;
                wbe_q   <= csr_wstrb & type_mask;
            end
            for (int unsigned i = 0; i < 4; i++) begin
                scratch_q[i] <= scratch_d[i];
            end
            status_q  <= status_d;
            evt_cnt_q <= evt_cnt_d;
            ctrl_q    <= ctrl_d;

            rd1_v_q  <= csr_read;
            if (csr_read) begin
                rd1_q <= rd_sel;
            end
            rvalid_q <= rd1_v_q;
            if (rd1_v_q) begin
                rdata_q <= rd1_q;
            end
        end
    end

    assign csr_slv_wready     = wready_q;
    assign csr_readdata       = rdata_q;
    assign csr_readdata_valid = rvalid_q;
    assign ctrl_out           = ctrl_q;

endmodule

// File: tb/tb_ofs_fim_csr_regbank.sv
// Scoreboard bench for ofs_fim_csr_regbank: read expectations are queued at issue and
// checked when csr_readdata_valid arrives; write handshake and side outputs checked inline.
`timescale 1ns/1ps

module tb_ofs_fim_csr_regbank;
    import ofs_csr_pkg::*;

    localparam int AW = ofs_fim_cfg_pkg::MMIO_ADDR_WIDTH;
    localparam logic [63:0] DFH = 64'h3000_0000_0000_1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             csr_write = 1'b0;
    logic [AW-1:0]    csr_waddr = '0;
    csr_access_type_t csr_write_type = FULL64;
    logic [63:0]      csr_wdata = '0;
    logic [7:0]       csr_wstrb = '0;
    logic             csr_slv_wready;
    logic             csr_read = 1'b0;
    logic [AW-1:0]    csr_raddr = '0;
    logic             csr_read_32b = 1'b0;
    logic [63:0]      csr_readdata;
    logic             csr_readdata_valid;
    logic [15:0]      evt_in = '0;
    logic [7:0]       ctrl_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_valid = 0;
    logic [63:0] exp_q[$];
    int vcyc_q[$];

    always #5 clk = ~clk;

    ofs_fim_csr_regbank #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (64),
        .WSTRB_WIDTH(8),
        .DFH_VALUE  (DFH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .csr_write         (csr_write),
        .csr_waddr         (csr_waddr),
        .csr_write_type    (csr_write_type),
        .csr_wdata         (csr_wdata),
        .csr_wstrb         (csr_wstrb),
        .csr_slv_wready    (csr_slv_wready),
        .csr_read          (csr_read),
        .csr_raddr         (csr_raddr),
        .csr_read_32b      (csr_read_32b),
        .csr_readdata      (csr_readdata),
        .csr_readdata_valid(csr_readdata_valid),
        .evt_in            (evt_in),
        .ctrl_out          (ctrl_out)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (csr_readdata_valid) begin
            n_valid++;
            vcyc_q.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid got=%h required=no valid", csr_readdata);
            end else begin
                e = exp_q.pop_front();
                if (csr_readdata !== e) begin
                    bad++;
                    $display("FAIL readdata got=%h required=%h", csr_readdata, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_read(input logic [AW-1:0] a, input logic b32, input logic [63:0] e);
        csr_read     = 1'b1;
        csr_raddr    = a;
        csr_read_32b = b32;
        exp_q.push_back(e);
        tick();
        csr_read     = 1'b0;
        csr_read_32b = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input csr_access_type_t t, input logic [63:0] d,
                            input logic [7:0] s, input logic [15:0] evt_c,
                            input logic rd_c, input logic [63:0] rd_c_exp);
        int   n = 0;
        logic acc = 1'b0;
        csr_write      = 1'b1;
        csr_waddr      = a;
        csr_write_type = t;
        csr_wdata      = d;
        csr_wstrb      = s;
        while (!acc && n < 20) begin
            acc = csr_slv_wready;
            tick();
            n++;
        end
        csr_write = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL write_accept got=0 required=1 addr=%h", a);
        end
        evt_in = evt_c;
        if (rd_c) begin
            csr_read  = 1'b1;
            csr_raddr = a;
            exp_q.push_back(rd_c_exp);
        end
        total++;
        if (csr_slv_wready !== 1'b0) begin
            bad++;
            $display("FAIL wready_commit got=%b required=0", csr_slv_wready);
        end
        tick();
        evt_in   = '0;
        csr_read = 1'b0;
        total++;
        if (csr_slv_wready !== 1'b1) begin
            bad++;
            $display("FAIL wready_after got=%b required=1", csr_slv_wready);
        end
    endtask

    task automatic test_reset();
        int t0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({csr_slv_wready, csr_readdata_valid, ctrl_out, csr_readdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%b/%h/%h required=0/0/00/0",
                     csr_slv_wready, csr_readdata_valid, ctrl_out, csr_readdata);
        end
        rst_n = 1'b1;
        total++;
        if (csr_slv_wready !== 1'b0) begin
            bad++;
            $display("FAIL wready_at_release got=%b required=0", csr_slv_wready);
        end
        tick();
        total++;
        if (csr_slv_wready !== 1'b1) begin
            bad++;
            $display("FAIL wready_rise got=%b required=1", csr_slv_wready);
        end
        vcyc_q.delete();
        t0 = cyc;
        issue_read(AW'(16'h00), 1'b0, DFH);
        drain("dfh");
        total++;
        if (vcyc_q.size() != 1 || vcyc_q[0] != t0 + 2) begin
            bad++;
            $display("FAIL read_latency got=%0d required=%0d", vcyc_q.size() > 0 ? vcyc_q[0] - t0 : -1, 2);
        end
        issue_read(AW'(16'h08), 1'b0, 64'h0);
        drain("scratch0_reset");
    endtask

    task automatic test_write_merge();
        do_write(AW'(16'h10), FULL64, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, '0, 1'b1, 64'h0);
        drain("merge_old0");
        do_write(AW'(16'h10), UPPER32, 64'h1111_2222_0000_0000, 8'hFF, '0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
        issue_read(AW'(16'h10), 1'b0, 64'h1111_2222_CAFE_F00D);
        drain("merge");
        do_write(AW'(16'h10), LOWER32, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, '0, 1'b0, 64'h0);
        issue_read(AW'(16'h10), 1'b0, 64'h1111_2222_CAFE_F00D);
        issue_read(AW'(16'h14), 1'b1, 64'h1111_2222_1111_2222);
        issue_read(AW'(16'h10), 1'b1, 64'h1111_2222_CAFE_F00D);
        drain("zero_be_and_32b");
    endtask

    task automatic test_status();
        evt_in = 16'h0008;
        tick();
        evt_in = '0;
        issue_read(AW'(16'h28), 1'b0, 64'h8);
        drain("status_set");
        do_write(AW'(16'h28), FULL64, 64'h8, 8'hFF, '0, 1'b0, 64'h0);
        issue_read(AW'(16'h28), 1'b0, 64'h0);
        drain("status_clear");
        evt_in = 16'h0008;
        tick();
        evt_in = '0;
        do_write(AW'(16'h28), FULL64, 64'h8, 8'hFF, 16'h0008, 1'b0, 64'h0);
        issue_read(AW'(16'h28), 1'b0, 64'h8);
        drain("status_set_wins");
        do_write(AW'(16'h28), FULL64, 64'h8, 8'h00, '0, 1'b0, 64'h0);
        issue_read(AW'(16'h28), 1'b0, 64'h8);
        drain("status_zero_be");
    endtask

    task automatic test_evt_count();
        evt_in = 16'h0001;
        repeat (5) tick();
        evt_in = '0;
        issue_read(AW'(16'h30), 1'b0, 64'h5);
        drain("evt_five");
        force dut.evt_cnt_q = 32'hFFFF_FFFE;
        tick();
        release dut.evt_cnt_q;
        evt_in = 16'h0001;
        repeat (3) tick();
        evt_in = '0;
        issue_read(AW'(16'h30), 1'b0, 64'h0000_0000_FFFF_FFFF);
        drain("evt_saturate");
        do_write(AW'(16'h30), FULL64, 64'h0, 8'hFF, 16'h0001, 1'b0, 64'h0);
        issue_read(AW'(16'h30), 1'b0, 64'h1);
        drain("evt_clear_with_event");
        do_write(AW'(16'h30), LOWER32, 64'h0, 8'hF0, '0, 1'b0, 64'h0);
        issue_read(AW'(16'h30), 1'b0, 64'h1);
        drain("evt_zero_be");
    endtask

    task automatic test_ctrl_unmapped();
        do_write(AW'(16'h38), FULL64, 64'hFFFF_FFFF_0000_00A5, 8'hFF, '0, 1'b0, 64'h0);
        total++;
        if (ctrl_out !== 8'hA5) begin
            bad++;
            $display("FAIL ctrl_out got=%h required=a5", ctrl_out);
        end
        issue_read(AW'(16'h3C), 1'b1, 64'h0);
        issue_read(AW'(16'h38), 1'b0, 64'hA5);
        issue_read(AW'(16'h40), 1'b0, 64'h0);
        drain("ctrl_reads");
        do_write(AW'(16'h48), FULL64, 64'h5555_6666_7777_8888, 8'hFF, '0, 1'b0, 64'h0);
        issue_read(AW'(16'h08), 1'b0, 64'h0);
        issue_read(AW'(16'h48), 1'b0, 64'h0);
        drain("unmapped_write");
    endtask

    task automatic test_back_to_back();
        do_write(AW'(16'h08), FULL64, 64'h0123_4567_89AB_CDEF, 8'hFF, '0, 1'b0, 64'h0);
        do_write(AW'(16'h18), FULL64, 64'hFEDC_BA98_7654_3210, 8'hFF, '0, 1'b0, 64'h0);
        vcyc_q.delete();
        issue_read(AW'(16'h08), 1'b0, 64'h0123_4567_89AB_CDEF);
        issue_read(AW'(16'h18), 1'b0, 64'hFEDC_BA98_7654_3210);
        drain("b2b");
        total++;
        if (vcyc_q.size() != 2 || vcyc_q[1] != vcyc_q[0] + 1) begin
            bad++;
            $display("FAIL b2b_consecutive got=%0d pulses required=2 adjacent", vcyc_q.size());
        end
        repeat (2) tick();
        total++;
        if (csr_readdata !== 64'hFEDC_BA98_7654_3210 || csr_readdata_valid !== 1'b0) begin
            bad++;
            $display("FAIL readdata_hold got=%h/%b required=fedcba9876543210/0",
                     csr_readdata, csr_readdata_valid);
        end
    endtask

    task automatic test_reset_abort();
        int   n = 0;
        int   nv;
        logic acc = 1'b0;
        do_write(AW'(16'h20), FULL64, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, '0, 1'b0, 64'h0);
        csr_write      = 1'b1;
        csr_waddr      = AW'(16'h20);
        csr_write_type = FULL64;
        csr_wdata      = 64'h1234_5678_9ABC_DEF0;
        csr_wstrb      = 8'hFF;
        while (!acc && n < 20) begin
            acc = csr_slv_wready;
            tick();
            n++;
        end
        csr_write = 1'b0;
        csr_read  = 1'b1;
        csr_raddr = AW'(16'h00);
        nv = n_valid;
        #2;
        rst_n = 1'b0;
        #1;
        csr_read = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        total++;
        if (n_valid != nv) begin
            bad++;
            $display("FAIL abort_read_valid got=%0d required=%0d", n_valid, nv);
        end
        issue_read(AW'(16'h20), 1'b0, 64'h0);
        drain("abort_write");
    endtask

    initial begin
        test_reset();
        test_write_merge();
        test_status();
        test_evt_count();
        test_ctrl_unmapped();
        test_back_to_back();
        test_reset_abort();
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
